// File: rtl/float_accum_12_pkg.sv
// Shared float12 field layout, constants, FSM encoding and helpers for the
// accumulator and the float12 adder.
package float_accum_12_pkg;

  localparam int FP12_W   = 12;
  localparam int EXP_W    = 5;
  localparam int MAN_W    = 6;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;

  localparam int SIGN_BIT = 11;
  localparam int EXP_HI   = 10;
  localparam int EXP_LO   = 6;
  localparam int MAN_HI   = 5;
  localparam int MAN_LO   = 0;

  localparam logic [FP12_W-1:0] FP12_ZERO    = 12'h000;
  localparam logic [FP12_W-2:0] FP12_SAT_MAG = 11'h7FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Leading-zero count of a 7-bit significand; an all-zero input gives 7.
  function automatic logic [2:0] lzc7(input logic [6:0] v);
    logic [2:0] n;
    logic       hit;
    n   = 3'd0;
    hit = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!hit && v[i]) hit = 1'b1;
      else if (!hit)    n   = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/float_accum_12_if.sv
// Handshake/data bundle between the multiplier, the accumulator and writeback.
interface float_accum_12_if
  import float_accum_12_pkg::*;
#(
  parameter int CNT_W = 10
);
  logic              start_i;
  logic [CNT_W-1:0]  len_i;
  logic [FP12_W-1:0] data_i;
  logic              valid_i;
  logic [FP12_W-1:0] data_o;
  logic              valid_o;
  logic              busy_o;

  modport master (output start_i, len_i, data_i, valid_i,
                  input  data_o, valid_o, busy_o);
  modport slave  (input  start_i, len_i, data_i, valid_i,
                  output data_o, valid_o, busy_o);
endinterface

// File: rtl/float_accum_12_add.sv
// Combinational float12 adder with truncation and saturation; also used by
// the adder-tree stage.
module float_add_12
  import float_accum_12_pkg::*;
(
  input  logic [FP12_W-1:0] i_a,
  input  logic [FP12_W-1:0] i_b,
  output logic [FP12_W-1:0] o_sum
);

  logic              w_a_ge;
  logic [FP12_W-1:0] w_l;
  logic [FP12_W-1:0] w_s;
  logic [EXP_W-1:0]  w_el;
  logic [EXP_W-1:0]  w_d;
  logic [6:0]        w_ml;
  logic [6:0]        w_ms;
  logic [7:0]        w_add;
  logic [6:0]        w_dif;
  logic [2:0]        w_lz;
  logic [MAN_W-1:0]  w_norm;
  logic [EXP_W:0]    w_exp_up;
  logic [EXP_W-1:0]  w_exp_up5;
  logic              w_sign;

  // Magnitude order on {exp,man} picks the operand that sets exponent and sign.
  assign w_a_ge    = i_a[EXP_HI:MAN_LO] >= i_b[EXP_HI:MAN_LO];
  assign w_l       = w_a_ge ? i_a : i_b;
  assign w_s       = w_a_ge ? i_b : i_a;
  assign w_sign    = w_l[SIGN_BIT];
  assign w_el      = w_l[EXP_HI:EXP_LO];
  assign w_d       = w_el - w_s[EXP_HI:EXP_LO];
  assign w_ml      = {1'b1, w_l[MAN_HI:MAN_LO]};
  assign w_ms      = {1'b1, w_s[MAN_HI:MAN_LO]} >> w_d;
  assign w_add     = {1'b0, w_ml} + {1'b0, w_ms};
  assign w_dif     = w_ml - w_ms;
  assign w_lz      = lzc7(w_dif);
  assign w_norm    = w_dif[MAN_W-1:0] << w_lz;
  assign w_exp_up  = {1'b0, w_el} + 6'd1;
  assign w_exp_up5 = w_exp_up[EXP_W-1:0];

  always_comb begin
    o_sum = FP12_ZERO;
    if (i_a[EXP_HI:EXP_LO] == '0) begin
      o_sum = (i_b[EXP_HI:EXP_LO] == '0) ? FP12_ZERO : i_b;
    end else if (i_b[EXP_HI:EXP_LO] == '0) begin
      o_sum = i_a;
    end else if (w_d >= 5'd7) begin
      o_sum = w_l;
    end else if (w_l[SIGN_BIT] == w_s[SIGN_BIT]) begin
      if (w_add[7]) begin
        if (w_exp_up >= 6'(EXP_MAX)) o_sum = {w_sign, FP12_SAT_MAG};
        else                         o_sum = {w_sign, w_exp_up5, w_add[6:1]};
      end else begin
        if (w_el == 5'(EXP_MAX)) o_sum = {w_sign, FP12_SAT_MAG};
        else                     o_sum = {w_sign, w_el, w_add[5:0]};
      end
    end else if (w_dif == '0) begin
      o_sum = FP12_ZERO;
    end else if (w_el <= {2'b00, w_lz}) begin
      o_sum = FP12_ZERO;
    end else begin
      o_sum = {w_sign, w_el - {2'b00, w_lz}, w_norm};
    end
  end

endmodule

// File: rtl/float_accum_12.sv
// Sequential float12 dot-product accumulator: sums len_i products from the
// multiplier and presents one registered result pulse per completed vector.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_i; valid_i ignored
// ST_ACCUM | adding each valid product; r_cnt counts remaining terms
// ST_DONE  | registering r_acc onto data_o with a one-cycle valid_o
module float_accum_12
  import float_accum_12_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input logic              clk_i,
  input logic              rst_n_i,
  float_accum_12_if.slave  bus
);

  state_t            r_state;
  logic [FP12_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [FP12_W-1:0] r_data;
  logic              r_valid;
  logic              r_busy;
  logic [FP12_W-1:0] w_sum;

  float_add_12 u_add (
    .i_a   (r_acc),
    .i_b   (bus.data_i),
    .o_sum (w_sum)
  );

  assign bus.data_o  = r_data;
  assign bus.valid_o = r_valid;
  assign bus.busy_o  = r_busy;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_acc   <= FP12_ZERO;
      r_cnt   <= '0;
      r_data  <= FP12_ZERO;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_ACCUM: begin
          // start_i wins over valid_i, so a restart also aborts a sum in flight.
          if (bus.start_i) begin
            r_acc   <= FP12_ZERO;
            r_cnt   <= bus.len_i;
            r_busy  <= 1'b1;
            r_state <= (bus.len_i == '0) ? ST_DONE : ST_ACCUM;
          end else if (r_state == ST_ACCUM && bus.valid_i) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_data  <= r_acc;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_accum_12.sv
// Scoreboard bench for float_accum_12: expected sums queued at stimulus time,
// checked with latency when valid_o pulses.
module tb_float_accum_12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  float_accum_12_if #(.CNT_W(10)) bus ();

  float_accum_12 #(.CNT_W(10)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          pulses   = 0;
  int          last_drive_cyc = 0;
  logic [11:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && bus.valid_o) begin
      logic [11:0] e;
      pulses++;
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("result", 32'(bus.data_o), 32'(e));
        check_eq("latency", 32'(cyc - last_drive_cyc), 2);
      end
    end
  end

  task automatic drive(input bit st, input int len, input bit v, input logic [11:0] d);
    bus.start_i = st;
    bus.len_i   = len[9:0];
    bus.valid_i = v;
    bus.data_i  = d;
    if (st || v) last_drive_cyc = cyc;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_result(input int target);
    int t;
    t = 0;
    while (pulses < target && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("result_timeout", 32'(pulses >= target), 1);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.len_i   = '0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    #12;
    check_eq("rst_data",  32'(bus.data_o),  0);
    check_eq("rst_valid", 32'(bus.valid_o), 0);
    check_eq("rst_busy",  32'(bus.busy_o),  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // valid_i in IDLE must not start anything
    drive(0, 0, 1, 12'h3C0);
    idle(3);
    check_eq("idle_no_pulse", 32'(pulses), 0);

    // 1.0 + 1.0 = 2.0
    exp_q.push_back(12'h400);
    drive(1, 2, 0, 12'h000);
    check_eq("busy_accum", 32'(bus.busy_o), 1);
    drive(0, 0, 1, 12'h3C0);
    drive(0, 0, 1, 12'h3C0);
    wait_result(1);
    idle(1);
    check_eq("t1_busy_low", 32'(bus.busy_o), 0);

    // three terms with gaps of two idle cycles
    exp_q.push_back(12'h420);
    drive(1, 3, 0, 12'h000);
    drive(0, 0, 1, 12'h3C0);
    idle(2);
    drive(0, 0, 1, 12'h3C0);
    idle(2);
    drive(0, 0, 1, 12'h3C0);
    wait_result(2);
    idle(3);
    check_eq("t2_one_pulse", 32'(pulses), 2);

    // exact cancellation, then a far-smaller addend that is absorbed
    exp_q.push_back(12'h000);
    drive(1, 2, 0, 12'h000);
    drive(0, 0, 1, 12'h3C0);
    drive(0, 0, 1, 12'hBC0);
    wait_result(3);
    exp_q.push_back(12'h3C0);
    drive(1, 2, 0, 12'h000);
    drive(0, 0, 1, 12'h3C0);
    drive(0, 0, 1, 12'h1C0);
    wait_result(4);

    // saturation, then zero-length vector
    exp_q.push_back(12'h7FF);
    drive(1, 2, 0, 12'h000);
    drive(0, 0, 1, 12'h7FF);
    drive(0, 0, 1, 12'h7FF);
    wait_result(5);
    exp_q.push_back(12'h000);
    drive(1, 0, 0, 12'h000);
    wait_result(6);

    // abort after two terms; restart carries a valid that must be ignored
    exp_q.push_back(12'h3E0);
    drive(1, 4, 0, 12'h000);
    drive(0, 0, 1, 12'h3E0);
    drive(0, 0, 1, 12'h3E0);
    drive(1, 1, 1, 12'h3E0);
    drive(0, 0, 1, 12'h3E0);
    wait_result(7);
    idle(3);
    check_eq("abort_pulses", 32'(pulses), 7);

    // asynchronous reset mid-accumulation
    drive(1, 4, 0, 12'h000);
    drive(0, 0, 1, 12'h3C0);
    check_eq("pre_rst_busy", 32'(bus.busy_o), 1);
    check_eq("pre_rst_data", 32'(bus.data_o), 32'h3E0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_data",  32'(bus.data_o),  0);
    check_eq("arst_valid", 32'(bus.valid_o), 0);
    check_eq("arst_busy",  32'(bus.busy_o),  0);
    #3;
    rst_n = 1'b1;
    idle(3);
    check_eq("post_rst_busy",   32'(bus.busy_o), 0);
    check_eq("post_rst_pulses", 32'(pulses), 7);

    // accumulator restarts cleanly from IDLE
    exp_q.push_back(12'h400);
    drive(1, 2, 0, 12'h000);
    drive(0, 0, 1, 12'h3C0);
    drive(0, 0, 1, 12'h3C0);
    wait_result(8);
    idle(2);
    check_eq("sb_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_accum_12.md
Name: float_accum_12

Overview:
- Sequential floating-point accumulator that directly consumes the 12-bit products of the float12 multiplier in the neural-processor datapath. It sums a programmable number of products into a single float12 dot-product result.
- Float12 format: sign[11], exponent[10:6] (bias 15), mantissa[5:0] with hidden leading 1. Any value with exponent 0 is zero.
- Rounding is truncation, consistent with the multiplier.
- Sits between the multiplier output and the activation/writeback stage.

Parameters:
- CNT_W, 10, width of the term counter; maximum vector length is 2^CNT_W - 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  reset; asynchronous, active-low.
- start_i  input  1  one-cycle pulse that begins a new accumulation.
- len_i  input  CNT_W  number of products to accumulate; sampled when start_i is high.
- data_i  input  12  float12 product from the multiplier.
- valid_i  input  1  data_i is valid this cycle.
- data_o  output  12  accumulated float12 result; holds its value between results.
- valid_o  output  1  one-cycle pulse; data_o carries a new result.
- busy_o  output  1  high while in ACCUM or DONE.

Behaviour:
- Reset is asynchronous and active-low: one clock, and rst_n_i low immediately forces state=IDLE, acc=12'h000, cnt=0, data_o=12'h000, valid_o=0, busy_o=0. This holds even mid-accumulation.
- State machine states: IDLE, ACCUM, DONE.
- IDLE:
  - valid_i is ignored.
  - On start_i: acc<=0 and cnt<=len_i.
  - If len_i==0, go to DONE (the result is 12'h000); otherwise go to ACCUM.
- ACCUM:
  - On each cycle with valid_i: acc <= fadd(acc, data_i) and cnt <= cnt-1.
  - When valid_i is high and cnt==1, go to DONE.
  - Cycles with valid_i low hold all state.
- DONE:
  - data_o<=acc and valid_o<=1, both registered, so valid_o is visible in the cycle after DONE is entered.
  - Then go to IDLE.
  - Latency from the last valid_i to valid_o is 2 cycles.
- start_i while in ACCUM aborts the current sum: acc is cleared, cnt is reloaded, and the FSM stays in (or enters) ACCUM. No valid_o is produced for the aborted sum.
- start_i in DONE is ignored.
- A valid_i in the same cycle as start_i is not accumulated.
- fadd(a,b) is combinational and settles within one cycle:
  - If a has exponent 0, the result is b; if b has exponent 0, the result is a. Zero is canonical 12'h000.
  - Otherwise swap the operands so that {exp,man} of the first operand L is >= that of the second operand S. Let d = eL - eS.
  - If d >= 7, the result is L.
  - Form mL = {1,manL} and mS = {1,manS} >> d, both 7 bits, truncated, with no guard bits.
  - Same sign: s = mL + mS (8 bits).
    - If s[7]=1: man = s[6:1] and exp = eL+1.
    - Otherwise man = s[5:0] and exp = eL.
    - If exp reaches 31, saturate to {sign,5'd31,6'h3F}.
  - Different sign: s = mL - mS.
    - If s==0, the result is 12'h000.
    - Otherwise let lz be the number of leading zeros in s[6:0]. Shift s left by lz, man = shifted[5:0], exp = eL - lz.
    - If eL <= lz, flush to 12'h000.
  - The result sign is the sign of L.
- An operand with exponent 31 is an ordinary value, with no Inf/NaN handling.
- The counter never wraps: cnt is only decremented in ACCUM, where cnt >= 1.

Decomposition:
- Shared include/localparams: FP12_W=12, EXP_W=5, MAN_W=6, EXP_BIAS=15, EXP_MAX=31, field bit positions, FP12_ZERO=12'h000, FP12_SAT_MAG=11'h7FF, and the FSM state encodings.
- Sub-module float_add_12 is purely combinational. It is reused by a later adder-tree stage.
- The FSM, counter, and acc/output registers stay in float_accum_12.

Test Plan:
- start_i, len_i=2; data 12'h3C0, 12'h3C0 on consecutive valid cycles -> valid_o pulse 2 cycles after the last valid_i, data_o=12'h400 (2.0), busy_o low afterwards.
- len_i=3; data 12'h3C0 ×3, with a valid_i gap of 2 idle cycles between terms -> data_o=12'h420 (3.0) with exactly one valid_o pulse.
- len_i=2; data 12'h3C0, 12'hBC0 -> data_o=12'h000. Then len_i=2; data 12'h3C0, 12'h1C0 (exponent 7, d=8) -> data_o=12'h3C0.
- len_i=2; data 12'h7FF, 12'h7FF -> data_o=12'h7FF (saturated). Then len_i=0 -> valid_o 2 cycles after start_i with data_o=12'h000.
- len_i=4, 2 terms of 12'h3E0, then start_i with len_i=1 and data 12'h3E0 -> exactly one valid_o with data_o=12'h3E0. Then assert rst_n_i low mid-accumulation -> outputs are 0 and state is IDLE immediately, without a clock edge.
